// File: rtl/cve2_rf_writeback_queue.sv
`timescale 1ns/1ps
// Purpose: write-back queue between the EX/LSU result channels and the dual-write-port
//          register file; keeps program order per destination register and exports a
//          pending-write bitmap for decode hazard checks.
// Latency: an entry accepted at edge T is presented on its write port in cycle T+1 at
//          the earliest (write ports are combinational from the FIFO heads).
// Backpressure: ex_ready_o / lsu_ready_o = channel FIFO not full; a same-cycle pop does
//          not free a slot for the push (no pass-through).
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   ex_valid_i/ex_ready_o/ex_rd_i/ex_wdata_i          channel 0 (execute) input
//   lsu_valid_i/lsu_ready_o/lsu_rd_i/lsu_wdata_i      channel 1 (load/store) input
//   waddr_a_o/wdata_a_o/we_a_o         RF write port A, driven from the channel 0 head
//   waddr_b_o/wdata_b_o/we_b_o         RF write port B, driven from the channel 1 head
//   pending_o                          bit r set while a queued write to xr exists
//   empty_o                            both FIFOs empty
module cve2_rf_writeback_queue #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_rd_i,
    input  logic [DataWidth-1:0] ex_wdata_i,

    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_rd_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,

    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o,

    output logic [4:0]           waddr_b_o,
    output logic [DataWidth-1:0] wdata_b_o,
    output logic                 we_b_o,

    output logic [31:0]          pending_o,
    output logic                 empty_o
);

    // At most 2*Depth entries are in flight, so a tag one bit wider than needed to
    // count them lets the MSB of the modular difference decide age.
    localparam int unsigned TW = $clog2(2 * Depth) + 1;
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    typedef struct packed {
        logic [4:0]           rd;
        logic [DataWidth-1:0] data;
        logic [TW-1:0]        tag;
    } entry_t;

    // Channel index 0 = execute (port A), 1 = load/store (port B).
    entry_t        mem_q  [2][Depth];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] wptr_q [2];
    logic [CW-1:0] cnt_q  [2];
    logic [TW-1:0] seq_q;

    entry_t        head_ent [2];
    entry_t        new_ent  [2];
    logic [1:0]    in_vld;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    head_vld;
    logic [1:0]    head_disc;
    logic [1:0]    we;
    logic          conflict;
    logic          ch0_older;
    logic [TW-1:0] age_diff;
    logic [TW-1:0] seq_d;

    // x0 writes, and the upper 16 registers on RV32E, are dropped without a write.
    function automatic logic is_discard(input logic [4:0] rd);
        return (rd == 5'd0) || (RV32E && rd[4]);
    endfunction

    assign in_vld = {lsu_valid_i, ex_valid_i};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            head_ent[c]  = mem_q[c][rptr_q[c]];
            head_vld[c]  = (cnt_q[c] != '0);
            head_disc[c] = is_discard(head_ent[c].rd);
            ready[c]     = (cnt_q[c] != CW'(Depth));
        end
    end

    assign push = in_vld & ready;

    // Same destination on both heads: only the older one may write this cycle, so the
    // register file never sees two writes to one address and the younger value lands last.
    assign conflict  = head_vld[0] && head_vld[1] && !head_disc[0] && !head_disc[1]
                       && (head_ent[0].rd == head_ent[1].rd);
    assign age_diff  = head_ent[0].tag - head_ent[1].tag;
    assign ch0_older = age_diff[TW-1];

    assign pop[0] = head_vld[0] && (!conflict || ch0_older);
    assign pop[1] = head_vld[1] && (!conflict || !ch0_older);
    assign we     = pop & ~head_disc;

    // When both channels accept together, ch0 is treated as the older instruction.
    always_comb begin
        new_ent[0].rd   = ex_rd_i;
        new_ent[0].data = ex_wdata_i;
        new_ent[0].tag  = seq_q;
        new_ent[1].rd   = lsu_rd_i;
        new_ent[1].data = lsu_wdata_i;
        new_ent[1].tag  = seq_q + TW'(push[0]);
    end

    assign seq_d = seq_q + TW'(push[0]) + TW'(push[1]);

    // Bitmap is built from the current contents, before this cycle's pops.
    always_comb begin
        logic [PW-1:0] off;
        pending_o = '0;
        off       = '0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < int'(Depth); i++) begin
                off = PW'(i) - rptr_q[c];
                if ((CW'(off) < cnt_q[c]) && !is_discard(mem_q[c][i].rd)) begin
                    pending_o[mem_q[c][i].rd] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            seq_q <= '0;
            for (int c = 0; c < 2; c++) begin
                rptr_q[c] <= '0;
                wptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            seq_q <= seq_d;
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem_q[c][wptr_q[c]] <= new_ent[c];
                    wptr_q[c]           <= wptr_q[c] + PW'(1);
                end
                if (pop[c]) begin
                    rptr_q[c] <= rptr_q[c] + PW'(1);
                end
                cnt_q[c] <= cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
            end
        end
    end

    assign ex_ready_o  = ready[0];
    assign lsu_ready_o = ready[1];

    assign we_a_o    = we[0];
    assign waddr_a_o = head_vld[0] ? head_ent[0].rd   : '0;
    assign wdata_a_o = head_vld[0] ? head_ent[0].data : '0;

    assign we_b_o    = we[1];
    assign waddr_b_o = head_vld[1] ? head_ent[1].rd   : '0;
    assign wdata_b_o = head_vld[1] ? head_ent[1].data : '0;

    assign empty_o = !head_vld[0] && !head_vld[1];

endmodule

// File: tb/tb_cve2_rf_writeback_queue.sv
`timescale 1ns/1ps
// Bench for cve2_rf_writeback_queue: directed scenarios plus a long random run, all
// checked every cycle against a queue-based program-order model.
module tb_cve2_rf_writeback_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, lsu_valid;
    logic [4:0]  ex_rd, lsu_rd;
    logic [31:0] ex_wdata, lsu_wdata;
    logic        ex_ready, lsu_ready, we_a, we_b, empty;
    logic [4:0]  waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b, pending;

    // Second instance configured for RV32E, driven only through its lsu channel.
    logic        e_ex_valid, e_lsu_valid;
    logic [4:0]  e_ex_rd, e_lsu_rd;
    logic [31:0] e_ex_wdata, e_lsu_wdata;
    logic        e_ex_ready, e_lsu_ready, e_we_a, e_we_b, e_empty;
    logic [4:0]  e_waddr_a, e_waddr_b;
    logic [31:0] e_wdata_a, e_wdata_b, e_pending;

    cve2_rf_writeback_queue #(.RV32E(1'b0), .DataWidth(32), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_rd_i(ex_rd), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata),
        .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
        .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
        .pending_o(pending), .empty_o(empty)
    );

    cve2_rf_writeback_queue #(.RV32E(1'b1), .DataWidth(32), .Depth(DEPTH)) dut_e (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_valid_i(e_ex_valid), .ex_ready_o(e_ex_ready), .ex_rd_i(e_ex_rd), .ex_wdata_i(e_ex_wdata),
        .lsu_valid_i(e_lsu_valid), .lsu_ready_o(e_lsu_ready), .lsu_rd_i(e_lsu_rd), .lsu_wdata_i(e_lsu_wdata),
        .waddr_a_o(e_waddr_a), .wdata_a_o(e_wdata_a), .we_a_o(e_we_a),
        .waddr_b_o(e_waddr_b), .wdata_b_o(e_wdata_b), .we_b_o(e_we_b),
        .pending_o(e_pending), .empty_o(e_empty)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int wr4     = 0;
    int wr_any  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is a plain queue; age is an unbounded issue counter.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
        int          seq;
    } ment_t;

    typedef struct packed {
        logic        we_a;
        logic [4:0]  wa;
        logic [31:0] da;
        logic        we_b;
        logic [4:0]  wb;
        logic [31:0] db;
        logic [31:0] pend;
        logic        empty;
        logic        rdy_a;
        logic        rdy_b;
        logic        pop_a;
        logic        pop_b;
    } exp_t;

    ment_t       mq0[$];
    ment_t       mq1[$];
    int          mseq = 0;
    logic [31:0] mrf    [32];
    logic [31:0] dut_rf [32];

    function automatic exp_t model_eval();
        exp_t e;
        logic h0, h1, d0, d1, cf, old0;
        e    = '0;
        h0   = (mq0.size() != 0);
        h1   = (mq1.size() != 0);
        d0   = 1'b0;
        d1   = 1'b0;
        cf   = 1'b0;
        old0 = 1'b1;
        if (h0) begin
            e.wa = mq0[0].rd;
            e.da = mq0[0].d;
            d0   = (mq0[0].rd == 5'd0);
        end
        if (h1) begin
            e.wb = mq1[0].rd;
            e.db = mq1[0].d;
            d1   = (mq1[0].rd == 5'd0);
        end
        if (h0 && h1 && !d0 && !d1) begin
            cf   = (mq0[0].rd == mq1[0].rd);
            old0 = (mq0[0].seq < mq1[0].seq);
        end
        e.pop_a = h0 && (!cf || old0);
        e.pop_b = h1 && (!cf || !old0);
        e.we_a  = e.pop_a && !d0;
        e.we_b  = e.pop_b && !d1;
        foreach (mq0[i]) if (mq0[i].rd != 5'd0) e.pend[mq0[i].rd] = 1'b1;
        foreach (mq1[i]) if (mq1[i].rd != 5'd0) e.pend[mq1[i].rd] = 1'b1;
        e.empty = !h0 && !h1;
        e.rdy_a = (mq0.size() < DEPTH);
        e.rdy_b = (mq1.size() < DEPTH);
        return e;
    endfunction

    initial begin
        exp_t  me;
        ment_t ent;
        bit    acc0, acc1;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq0.delete();
                mq1.delete();
                mseq = 0;
            end else begin
                me   = model_eval();
                acc0 = ex_valid  && (mq0.size() < DEPTH);
                acc1 = lsu_valid && (mq1.size() < DEPTH);
                if (me.we_a) mrf[me.wa] = me.da;
                if (me.we_b) mrf[me.wb] = me.db;
                if (me.pop_a) void'(mq0.pop_front());
                if (me.pop_b) void'(mq1.pop_front());
                if (acc0) begin
                    ent.rd = ex_rd; ent.d = ex_wdata; ent.seq = mseq; mseq++;
                    mq0.push_back(ent);
                end
                if (acc1) begin
                    ent.rd = lsu_rd; ent.d = lsu_wdata; ent.seq = mseq; mseq++;
                    mq1.push_back(ent);
                end
            end
        end
    end

    // Per-cycle comparison, sampled mid-cycle; also records the writes the RF will take.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e = model_eval();
                chk("we_a",      we_a,      e.we_a);
                chk("waddr_a",   waddr_a,   e.wa);
                chk("wdata_a",   wdata_a,   e.da);
                chk("we_b",      we_b,      e.we_b);
                chk("waddr_b",   waddr_b,   e.wb);
                chk("wdata_b",   wdata_b,   e.db);
                chk("pending",   pending,   e.pend);
                chk("empty",     empty,     e.empty);
                chk("ex_ready",  ex_ready,  e.rdy_a);
                chk("lsu_ready", lsu_ready, e.rdy_b);
                if (rst_n) begin
                    if (we_a) begin dut_rf[waddr_a] = wdata_a; wr_any++; if (waddr_a == 5'd4) wr4++; end
                    if (we_b) begin dut_rf[waddr_b] = wdata_b; wr_any++; if (waddr_b == 5'd4) wr4++; end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Alternating ex/lsu writes to one register, each held until accepted; stops after
    // max_cyc cycles whether or not all six were taken.
    task automatic drive_pairs(input logic [4:0] rd, input logic [31:0] base, input int max_cyc,
                               output int n_ex, output int n_lsu, output bit saw_full);
        bit acc_e, acc_l;
        n_ex = 0; n_lsu = 0; saw_full = 1'b0;
        for (int c = 0; c < max_cyc && (n_ex < 3 || n_lsu < 3); c++) begin
            ex_valid  = (n_ex < 3);   ex_rd  = rd; ex_wdata  = base + 32'(2 * n_ex);
            lsu_valid = (n_lsu < 3);  lsu_rd = rd; lsu_wdata = base + 32'(2 * n_lsu + 1);
            if (!ex_ready) saw_full = 1'b1;
            acc_e = ex_valid && ex_ready;
            acc_l = lsu_valid && lsu_ready;
            tick();
            if (acc_e) n_ex++;
            if (acc_l) n_lsu++;
        end
        ex_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    function automatic logic [4:0] rand_rd();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        int n_ex, n_lsu;
        bit saw_full;
        foreach (mrf[i])    mrf[i]    = '0;
        foreach (dut_rf[i]) dut_rf[i] = '0;
        rst_n = 1'b0;
        ex_valid = 0; ex_rd = 0; ex_wdata = 0; lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
        e_ex_valid = 0; e_ex_rd = 0; e_ex_wdata = 0; e_lsu_valid = 0; e_lsu_rd = 0; e_lsu_wdata = 0;
        tick(); tick();
        chk_en = 1'b1;

        // 1. reset holds with valid inputs, then a single write to x5
        ex_valid = 1; ex_rd = 5'd9; ex_wdata = 32'h99; lsu_valid = 1; lsu_rd = 5'd9; lsu_wdata = 32'h98;
        tick(); tick();
        chk("t1_rst_we_a", we_a, 1'b0);
        chk("t1_rst_we_b", we_b, 1'b0);
        chk("t1_rst_pending", pending, 32'h0);
        chk("t1_rst_empty", empty, 1'b1);
        chk("t1_rst_ready", {ex_ready, lsu_ready}, 2'b11);
        rst_n = 1; ex_valid = 1; ex_rd = 5'd5; ex_wdata = 32'hA5; lsu_valid = 0;
        tick();
        ex_valid = 0;
        chk("t1_we_a", we_a, 1'b1);
        chk("t1_waddr_a", waddr_a, 5'd5);
        chk("t1_wdata_a", wdata_a, 32'hA5);
        chk("t1_pending_set", pending, 32'h0000_0020);
        tick();
        chk("t1_pending_clr", pending, 32'h0);
        chk("t1_empty", empty, 1'b1);

        // 2. same-cycle pair to x7: ex first, lsu second
        ex_valid = 1; ex_rd = 5'd7; ex_wdata = 32'd1;
        lsu_valid = 1; lsu_rd = 5'd7; lsu_wdata = 32'd2;
        tick();
        ex_valid = 0; lsu_valid = 0;
        chk("t2_c1_we", {we_a, we_b}, 2'b10);
        chk("t2_c1_wdata_a", wdata_a, 32'd1);
        tick();
        chk("t2_c2_we", {we_a, we_b}, 2'b01);
        chk("t2_c2_wdata_b", wdata_b, 32'd2);
        tick();
        chk("t2_x7", dut_rf[7], 32'd2);

        // 3. lsu write to x3 held behind an older ex write, then beats a younger ex write
        ex_valid = 1; ex_rd = 5'd3; ex_wdata = 32'h05;
        lsu_valid = 1; lsu_rd = 5'd3; lsu_wdata = 32'h10;
        tick();
        lsu_valid = 0; ex_wdata = 32'h20;
        chk("t3_c1_we", {we_a, we_b}, 2'b10);
        chk("t3_c1_wdata_a", wdata_a, 32'h05);
        tick();
        ex_valid = 0;
        chk("t3_c2_we", {we_a, we_b}, 2'b01);
        chk("t3_c2_wdata_b", wdata_b, 32'h10);
        tick();
        chk("t3_c3_wdata_a", {we_a, wdata_a}, {1'b1, 32'h20});
        tick();
        chk("t3_x3", dut_rf[3], 32'h20);

        // 4. x0 discard; RV32E instance drops x17 and keeps x1
        ex_valid = 1; ex_rd = 5'd0; ex_wdata = 32'hFF;
        tick();
        ex_valid = 0;
        chk("t4_x0_we", we_a, 1'b0);
        chk("t4_x0_pending", pending, 32'h0);
        chk("t4_x0_queued", empty, 1'b0);
        tick();
        chk("t4_x0_empty", empty, 1'b1);
        e_lsu_valid = 1; e_lsu_rd = 5'd17; e_lsu_wdata = 32'h11;
        tick();
        e_lsu_valid = 0;
        chk("t4_e17_we", e_we_b, 1'b0);
        chk("t4_e17_pending", e_pending, 32'h0);
        tick();
        chk("t4_e17_empty", e_empty, 1'b1);
        e_lsu_valid = 1; e_lsu_rd = 5'd1; e_lsu_wdata = 32'h22;
        tick();
        e_lsu_valid = 0;
        chk("t4_e1_write", {e_we_b, e_waddr_b, e_wdata_b}, {1'b1, 5'd1, 32'h22});
        chk("t4_e1_pending", e_pending, 32'h2);
        chk("t4_e_porta_idle", {e_we_a, e_waddr_a, e_wdata_a}, 38'h0);
        chk("t4_e_ready", {e_ex_ready, e_lsu_ready}, 2'b11);
        tick();
        chk("t4_e_empty", e_empty, 1'b1);

        // 5. back-to-back conflicts on x4 fill the ex FIFO
        wr4 = 0;
        drive_pairs(5'd4, 32'h400, 30, n_ex, n_lsu, saw_full);
        chk("t5_all_accepted", {8'(n_ex), 8'(n_lsu)}, {8'd3, 8'd3});
        chk("t5_ex_full_seen", saw_full, 1'b1);
        repeat (6) tick();
        chk("t5_write_count", wr4, 6);
        chk("t5_x4", dut_rf[4], 32'h405);
        chk("t5_empty", empty, 1'b1);

        // 6. reset while entries are queued on both channels
        drive_pairs(5'd4, 32'h500, 3, n_ex, n_lsu, saw_full);
        chk("t6_queued", empty, 1'b0);
        rst_n = 0;
        tick();
        rst_n = 1;
        wr_any = 0;
        chk("t6_pending", pending, 32'h0);
        chk("t6_empty", empty, 1'b1);
        repeat (4) tick();
        chk("t6_no_writes", wr_any, 0);
        ex_valid = 1; ex_rd = 5'd6; ex_wdata = 32'h61;
        lsu_valid = 1; lsu_rd = 5'd6; lsu_wdata = 32'h62;
        tick();
        ex_valid = 0; lsu_valid = 0;
        chk("t6_order_after_rst", {we_a, we_b, wdata_a}, {2'b10, 32'h61});
        repeat (3) tick();

        // random run, many tag wraps, occasional reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_rd     = rand_rd();
            ex_wdata  = $urandom;
            lsu_valid = ($urandom_range(0, 3) != 0);
            lsu_rd    = rand_rd();
            lsu_wdata = $urandom;
            tick();
        end
        rst_n = 1; ex_valid = 0; lsu_valid = 0;
        repeat (8) tick();
        chk("rand_drained", empty, 1'b1);
        for (int r = 1; r < 32; r++) chk($sformatf("rf_x%0d", r), dut_rf[r], mrf[r]);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
